// File: rtl/iter_shifter_if.sv
//==============================================================================
// Module      : iter_shifter_if
// Description : Request/result bundle between the control FSM and iter_shifter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface iter_shifter_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
) ();
    logic             start;
    logic [2:0]       command;
    logic [WIDTH-1:0] in;
    logic [AW-1:0]    shift_val;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             zero;
    logic             carry;

    modport master (
        output start,
        output command,
        output in,
        output shift_val,
        input  out,
        input  busy,
        input  done,
        input  zero,
        input  carry
    );

    modport slave (
        input  start,
        input  command,
        input  in,
        input  shift_val,
        output out,
        output busy,
        output done,
        output zero,
        output carry
    );
endinterface

`default_nettype wire

// File: rtl/iter_shifter.sv
//==============================================================================
// Module      : iter_shifter
// Description : Multicycle shift/rotate unit, STEP bit positions per clock.
//               Optional ISHIFT_BARREL_EN: whole shift in one SHIFT cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module iter_shifter #(
    parameter int WIDTH = 8,
    parameter int AW    = 8,
    parameter int STEP  = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    iter_shifter_if.slave bus
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;

    localparam logic [2:0] C_PASS = 3'b000;
    localparam logic [2:0] C_LSR  = 3'b001;
    localparam logic [2:0] C_ASR  = 3'b010;
    localparam logic [2:0] C_ROR  = 3'b011;
    localparam logic [2:0] C_ROL  = 3'b100;
    localparam logic [2:0] C_LSL  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [CW-1:0]    r_rem;
    logic [2:0]       r_mode;
    logic             r_sign;
    logic             r_carry_w;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;
    logic             r_done;
    logic             r_zero;
    logic             r_carry;

    logic [AW+CW-1:0]   w_sv_ext;
    logic [CW-1:0]      w_n;
    logic [2:0]         w_mode;
    logic [CW-1:0]      w_amt;
    logic [WIDTH-1:0]   w_fill_r;
    logic [WIDTH-1:0]   w_fill_l;
    logic [2*WIDTH:0]   w_wide_r;
    logic [2*WIDTH:0]   w_wide_l;
    logic [WIDTH-1:0]   w_res;
    logic               w_cry;

    assign w_sv_ext = {{CW{1'b0}}, bus.shift_val};

    // Effective amount and mode are decided at accept so SHIFT only counts down.
    always_comb begin
        w_n    = '0;
        w_mode = C_PASS;
        case (bus.command)
            C_ROR, C_ROL: begin
                w_n    = {1'b0, w_sv_ext[LW-1:0]};
                w_mode = bus.command;
            end
            C_LSR, C_ASR, C_LSL: begin
                w_n    = (w_sv_ext >= (AW+CW)'(WIDTH)) ? CW'(WIDTH) : w_sv_ext[CW-1:0];
                w_mode = bus.command;
            end
            default: begin
                w_n    = '0;
                w_mode = C_PASS;
            end
        endcase
    end

`ifdef ISHIFT_BARREL_EN
    assign w_amt = r_rem;
`else
    assign w_amt = (r_rem > CW'(STEP)) ? CW'(STEP) : r_rem;
`endif

    // The spare low (right) or high (left) bit captures the last bit shifted out.
    always_comb begin
        w_fill_r = '0;
        w_fill_l = '0;
        if (r_mode == C_ROR) begin
            w_fill_r = r_work;
        end else if (r_mode == C_ASR) begin
            w_fill_r = {WIDTH{r_sign}};
        end
        if (r_mode == C_ROL) begin
            w_fill_l = r_work;
        end
        w_wide_r = {w_fill_r, r_work, 1'b0} >> w_amt;
        w_wide_l = {1'b0, r_work, w_fill_l} << w_amt;
        if ((r_mode == C_ROL) || (r_mode == C_LSL)) begin
            w_res = WIDTH'(w_wide_l >> WIDTH);
            w_cry = w_wide_l[2*WIDTH];
        end else begin
            w_res = WIDTH'(w_wide_r >> 1);
            w_cry = w_wide_r[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_work    <= '0;
            r_rem     <= '0;
            r_mode    <= C_PASS;
            r_sign    <= 1'b0;
            r_carry_w <= 1'b0;
            r_out     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_zero    <= 1'b1;
            r_carry   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (bus.start) begin
                        r_work    <= bus.in;
                        r_rem     <= w_n;
                        r_mode    <= w_mode;
                        r_sign    <= bus.in[WIDTH-1];
                        r_carry_w <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (r_rem != '0) begin
                        r_work    <= w_res;
                        r_rem     <= r_rem - w_amt;
                        r_carry_w <= w_cry;
                    end else begin
                        r_out     <= r_work;
                        r_zero    <= (r_work == '0);
                        r_carry   <= r_carry_w;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FINISH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out   = r_out;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.zero  = r_zero;
    assign bus.carry = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_iter_shifter.sv
//==============================================================================
// Module      : tb_iter_shifter
// Description : Directed bench for iter_shifter, STEP=1 and STEP=4 instances.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_iter_shifter;

    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    iter_shifter_if #(.WIDTH(8), .AW(8)) bus1 ();
    iter_shifter_if #(.WIDTH(8), .AW(8)) bus4 ();

    iter_shifter #(.WIDTH(8), .AW(8), .STEP(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    iter_shifter #(.WIDTH(8), .AW(8), .STEP(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 out, 1 busy, 2 done, 3 zero, 4 carry
    function automatic logic [31:0] obs(input int sel, input int which);
        logic [31:0] v;
        v = '0;
        case (which)
            0: v = {24'd0, (sel == 4) ? bus4.out : bus1.out};
            1: v = {31'd0, (sel == 4) ? bus4.busy : bus1.busy};
            2: v = {31'd0, (sel == 4) ? bus4.done : bus1.done};
            3: v = {31'd0, (sel == 4) ? bus4.zero : bus1.zero};
            default: v = {31'd0, (sel == 4) ? bus4.carry : bus1.carry};
        endcase
        return v;
    endfunction

    function automatic int kexp(input int n, input int step);
`ifdef ISHIFT_BARREL_EN
        return (n > 0) ? 1 : 0;
`else
        return (n + step - 1) / step;
`endif
    endfunction

    task automatic drive(input int sel, input logic [2:0] cmd, input logic [7:0] din,
                         input logic [7:0] sv);
        if (sel == 4) begin
            bus4.command = cmd; bus4.in = din; bus4.shift_val = sv; bus4.start = 1'b1;
        end else begin
            bus1.command = cmd; bus1.in = din; bus1.shift_val = sv; bus1.start = 1'b1;
        end
    endtask

    // Drop start and scramble operands so late input changes would show up.
    task automatic release_start(input int sel);
        if (sel == 4) begin
            bus4.start = 1'b0; bus4.in = ~bus4.in; bus4.shift_val = 8'd0; bus4.command = 3'b000;
        end else begin
            bus1.start = 1'b0; bus1.in = ~bus1.in; bus1.shift_val = 8'd0; bus1.command = 3'b000;
        end
    endtask

    task automatic wait_done(input int sel, output int edges, output int nbusy);
        edges = 0;
        nbusy = 0;
        while (obs(sel, 2) != 32'd1 && edges < 40) begin
            if (obs(sel, 1) == 32'd1) nbusy++;
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input int sel, input string tag, input logic [2:0] cmd,
                          input logic [7:0] din, input logic [7:0] sv,
                          input logic [7:0] exp_out, input logic exp_c, input int n);
        int e, nb, k;
        k = kexp(n, sel);
        drive(sel, cmd, din, sv);
        tick();
        release_start(sel);
        wait_done(sel, e, nb);
        check({tag, "_done"},  obs(sel, 2), 32'd1);
        check({tag, "_lat"},   32'(e),  32'(k + 1));
        check({tag, "_busyn"}, 32'(nb), 32'(k + 1));
        check({tag, "_out"},   obs(sel, 0), {24'd0, exp_out});
        check({tag, "_carry"}, obs(sel, 4), {31'd0, exp_c});
        check({tag, "_zero"},  obs(sel, 3), {31'd0, (exp_out == 8'd0)});
        check({tag, "_busy0"}, obs(sel, 1), 32'd0);
        tick();
        check({tag, "_pulse"}, obs(sel, 2), 32'd0);
    endtask

    task automatic count_dones(input int sel, input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (obs(sel, 2) == 32'd1) nd++;
        end
    endtask

    initial begin
        int e, nb, nd;
        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.command = 3'b000; bus1.in = 8'h00; bus1.shift_val = 8'h00;
        bus4.start = 1'b0; bus4.command = 3'b000; bus4.in = 8'h00; bus4.shift_val = 8'h00;
        tick();
        tick();
        check("rst_out",   obs(1, 0), 32'h00);
        check("rst_busy",  obs(1, 1), 32'd0);
        check("rst_done",  obs(1, 2), 32'd0);
        check("rst_zero",  obs(1, 3), 32'd1);
        check("rst_carry", obs(1, 4), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", obs(1, 1), 32'd0);

        run_op(1, "lsr3",   3'b001, 8'h96, 8'd3,   8'h12, 1'b1, 3);
        run_op(1, "asr9",   3'b010, 8'h96, 8'd9,   8'hFF, 1'b1, 8);
        run_op(1, "asr9z",  3'b010, 8'h16, 8'd9,   8'h00, 1'b0, 8);
        run_op(1, "rol11",  3'b100, 8'h96, 8'd11,  8'hB4, 1'b0, 3);
        run_op(1, "ror8",   3'b011, 8'h96, 8'd8,   8'h96, 1'b0, 0);
        run_op(1, "ror3",   3'b011, 8'h96, 8'd3,   8'hD2, 1'b1, 3);
        run_op(1, "pass0",  3'b000, 8'h5A, 8'd7,   8'h5A, 1'b0, 0);
        run_op(1, "pass7",  3'b111, 8'hA5, 8'd2,   8'hA5, 1'b0, 0);
        run_op(1, "lsl1",   3'b101, 8'h96, 8'd1,   8'h2C, 1'b1, 1);
        run_op(1, "lsr200", 3'b001, 8'h96, 8'd200, 8'h00, 1'b1, 8);
        run_op(1, "asr2",   3'b010, 8'h96, 8'd2,   8'hE5, 1'b1, 2);

        run_op(4, "s4lsl5", 3'b101, 8'h96, 8'd5,   8'hC0, 1'b0, 5);
        run_op(4, "s4asr5", 3'b010, 8'h96, 8'd5,   8'hFC, 1'b1, 5);
        run_op(4, "s4ror6", 3'b011, 8'h96, 8'd6,   8'h5A, 1'b0, 6);
        run_op(4, "s4lsr8", 3'b001, 8'h96, 8'd8,   8'h00, 1'b1, 8);
        run_op(4, "s4ror1", 3'b011, 8'h96, 8'd1,   8'h4B, 1'b0, 1);

        // Start while busy must be ignored.
        drive(1, 3'b001, 8'h96, 8'd3);
        tick();
        release_start(1);
        tick();
        tick();
        drive(1, 3'b101, 8'hFF, 8'd1);
        tick();
        release_start(1);
        wait_done(1, e, nb);
        check("coll_done",  obs(1, 2), 32'd1);
        check("coll_lat",   32'(e + 3), 32'(kexp(3, 1) + 1));
        check("coll_out",   obs(1, 0), 32'h12);
        check("coll_carry", obs(1, 4), 32'd1);
        count_dones(1, 8, nd);
        check("coll_ndone", 32'(nd), 32'd0);

        // Start in the FINISH cycle is accepted directly.
        drive(1, 3'b100, 8'h96, 8'd3);
        tick();
        release_start(1);
        wait_done(1, e, nb);
        check("fin_a_out", obs(1, 0), 32'hB4);
        drive(1, 3'b001, 8'h81, 8'd1);
        tick();
        release_start(1);
        check("fin_b_busy", obs(1, 1), 32'd1);
        check("fin_b_done", obs(1, 2), 32'd0);
        wait_done(1, e, nb);
        check("fin_b_lat",   32'(e), 32'(kexp(1, 1) + 1));
        check("fin_b_out",   obs(1, 0), 32'h40);
        check("fin_b_carry", obs(1, 4), 32'd1);
        check("fin_b_zero",  obs(1, 3), 32'd0);
        tick();

        // Reset in the middle of SHIFT aborts without a done pulse.
        drive(1, 3'b001, 8'h96, 8'd3);
        tick();
        release_start(1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mrst_out",   obs(1, 0), 32'h00);
        check("mrst_busy",  obs(1, 1), 32'd0);
        check("mrst_zero",  obs(1, 3), 32'd1);
        check("mrst_done",  obs(1, 2), 32'd0);
        check("mrst_carry", obs(1, 4), 32'd0);
        rst_n = 1'b1;
        count_dones(1, 6, nd);
        check("mrst_ndone", 32'(nd), 32'd0);
        run_op(1, "post", 3'b101, 8'h96, 8'd1, 8'h2C, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Parametrised, multicycle shift/rotate unit for the multicycle datapath. Supports pass, logical, arithmetic and rotate modes with a start/busy/done handshake, and shifts STEP bit positions per clock. Replaces the single-cycle 8-bit shifter where area matters more than latency. It is driven by the control FSM, and its result is registered for the writeback stage.

Parameters:
WIDTH, 8, data width; power of two, >= 4
AW, 8, shift-amount width
STEP, 1, bit positions shifted per cycle; power of two, 1..WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when busy=0
command  input  3  operation code, sampled on accept
in  input  WIDTH  operand, sampled on accept
shift_val  input  AW  unsigned shift amount, sampled on accept
out  output  WIDTH  registered result, held until next completion
busy  output  1  high from accept edge until completion edge
done  output  1  one-cycle pulse, out valid
zero  output  1  out == 0, updated with out
carry  output  1  last bit shifted or rotated out; 0 if effective amount is 0

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE, out=0, busy=0, done=0, zero=1, carry=0. Reset mid-operation aborts it; no done pulse is issued.
- Command decode:
  - 000, 110, 111: pass.
  - 001: logical right.
  - 010: arithmetic right.
  - 011: rotate right.
  - 100: rotate left.
  - 101: logical left.
- Effective amount N:
  - Rotates: N = shift_val mod WIDTH.
  - Logical and arithmetic shifts: N = min(shift_val, WIDTH).
  - Pass: N = 0.
- FSM states are IDLE, SHIFT and FINISH.
- IDLE:
  - On start=1, latch in, N and the mode into the working registers, set busy=1, go to SHIFT.
  - done is 0 in every cycle that does not immediately follow completion.
- SHIFT:
  - Each cycle with remaining > 0: shift or rotate the working register by min(STEP, remaining), subtract that from remaining, record the last bit out into carry_w.
  - When remaining == 0: out<=work, zero<=(work==0), carry<=carry_w, busy<=0, go to FINISH.
- FINISH: done=1 for exactly this one cycle; return to IDLE. A start is accepted in FINISH (busy already 0), and the FSM goes directly to SHIFT.
- Latency: with K = ceil(N/STEP), done is high in cycle K+2 after the accept edge. busy is high for K+1 cycles.
- Fill rules:
  - Logical shifts fill with 0.
  - Arithmetic right fills with the operand MSB captured at accept.
  - N == WIDTH gives all zeros (logical) or all sign bits (arithmetic).
- start while busy=1: ignored; the operation in flight is unaffected.
- Inputs are only sampled on accept; later changes have no effect on the result.

Optional Feature:
ISHIFT_BARREL_EN:
- Defined: SHIFT performs the whole effective shift in one cycle using a combinational barrel network, so K=1 whenever N>0 (K=0 when N=0). STEP is ignored. Results and flags are identical to the iterative path.
- Undefined: iterative path only, as specified above.

Test Plan:
- WIDTH=8, STEP=1, in=0x96, cmd=001, shift_val=3 -> out=0x12, carry=1, zero=0; done in cycle 5 after accept; busy high 4 cycles.
- in=0x96, cmd=010, shift_val=9 -> N=8, out=0xFF, carry=1, done in cycle 10; same with in=0x16 -> out=0x00, zero=1, carry=0.
- in=0x96, cmd=100, shift_val=11 -> N=3, out=0xB4, carry=0, done in cycle 5; cmd=011, shift_val=8 -> N=0, out=0x96, carry=0, done in cycle 2.
- STEP=4 instance, in=0x96, cmd=101, shift_val=5 -> out=0xC0, carry=0, done in cycle 4; with ISHIFT_BARREL_EN -> same result, done in cycle 3.
- Pulse start again 2 cycles into a 3-bit shift with different in -> second request ignored, single done, first result only; start in the FINISH cycle -> accepted, second result follows.
- Assert rst_n=0 mid-SHIFT -> next cycle out=0, busy=0, zero=1, no done pulse; a new start afterwards completes normally.
